// File: rtl/seq_1010_frame_tx_pkg.sv
// Shared definitions for the 1010 frame transmitter and its checkers.
//   frame_state_t : frame FSM encodings (IDLE..GAP), also exported on cs
//   trk_state_t   : post-header suffix tracker encodings (T0..T101)
//   HDR_PATTERN   : sync header, sent MSB first
//   MIN_GAP_BITS  : smallest gap that returns the tracker to T0
package seq_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        STUFF = 3'd3,
        GAP   = 3'd4
    } frame_state_t;

    typedef enum logic [1:0] {
        T0   = 2'd0,
        T1   = 2'd1,
        T10  = 2'd2,
        T101 = 2'd3
    } trk_state_t;

    localparam logic [3:0] HDR_PATTERN  = 4'b1010;
    localparam int         MIN_GAP_BITS = 2;

endpackage

// File: rtl/seq_1010_frame_tx_if.sv
// Handshake/serial bundle of the frame transmitter.
//   Start/Data          : frame request and payload (driven by master)
//   Out/Busy/Done/Stuff : serial stream and status (driven by slave)
//   cs                  : current frame FSM state for debug
interface seq_1010_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Data;
    logic             Out;
    logic             Busy;
    logic             Done;
    logic             Stuff;
    logic [2:0]       cs;

    modport master (output Start, Data, input Out, Busy, Done, Stuff, cs);
    modport slave  (input Start, Data, output Out, Busy, Done, Stuff, cs);
endinterface

// File: rtl/seq_1010_frame_tx_tracker.sv
// Suffix tracker for the post-header bit stream: remembers how much of a
// 1010 pattern the most recent output bits form.
//   Clk, Rst : clock, asynchronous active-high reset
//   en       : advance with bit_in (one post-header bit emitted)
//   clr      : force T0 (has priority over en)
//   bit_in   : the bit being emitted
//   state    : current suffix state
module seq_1010_tracker
    import seq_fsm_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       en,
    input  logic       clr,
    input  logic       bit_in,
    output trk_state_t state
);

    trk_state_t state_reg;
    trk_state_t state_next;

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = T0;
        end else if (en) begin
            case (state_reg)
                T0:      state_next = bit_in ? T1   : T0;
                T1:      state_next = bit_in ? T1   : T10;
                T10:     state_next = bit_in ? T101 : T0;
                T101:    state_next = bit_in ? T1   : T0;
                default: state_next = T0;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= T0;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/seq_1010_frame_tx.sv
// Serial frame transmitter: 1010 header, WIDTH-bit payload MSB first with
// a 1 stuffed wherever a 1010 would otherwise form, then GAP_BITS zeros.
// GAP_BITS must be at least MIN_GAP_BITS so the stream ends in T0.
//   Clk, Rst : clock, asynchronous active-high reset
//   bus      : Start/Data in; Out/Busy/Done/Stuff/cs out (all registered)
module seq_1010_frame_tx
    import seq_fsm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int GAP_BITS = MIN_GAP_BITS
) (
    input  logic                 Clk,
    input  logic                 Rst,
    seq_1010_frame_tx_if.slave   bus
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP_BITS + 1);

    // state_reg is the state that produced the bit currently on Out
    frame_state_t     state_reg,   state_next;
    logic [WIDTH-1:0] shreg_reg,   shreg_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [2:0]       hdr_cnt_reg, hdr_cnt_next;
    logic             out_reg,     out_next;
    logic             busy_reg,    busy_next;
    logic             done_reg,    done_next;
    logic             stuff_reg,   stuff_next;
    logic             payload;
    logic             trk_en;
    trk_state_t       trk;

    // trk always includes the bit currently on Out, so every decision
    // below sees the full post-header history.
    assign trk_en = (state_next == DATA) || (state_next == STUFF) ||
                    (state_next == GAP);

    seq_1010_tracker u_tracker (
        .Clk    (Clk),
        .Rst    (Rst),
        .en     (trk_en),
        .clr    (!trk_en),
        .bit_in (out_next),
        .state  (trk)
    );

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        hdr_cnt_next = hdr_cnt_reg;
        out_next     = 1'b0;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        stuff_next   = 1'b0;
        payload      = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (bus.Start) begin
                    state_next   = HDR;
                    shreg_next   = bus.Data;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    hdr_cnt_next = 3'd1;
                    out_next     = HDR_PATTERN[3];
                    busy_next    = 1'b1;
                end
            end
            HDR: begin
                // hdr_cnt counts header bits already sent; ~cnt picks the next
                if (hdr_cnt_reg < 3'd4) begin
                    out_next     = HDR_PATTERN[~hdr_cnt_reg[1:0]];
                    hdr_cnt_next = hdr_cnt_reg + 3'd1;
                end else begin
                    payload = 1'b1;
                end
            end
            DATA, STUFF: begin
                payload = 1'b1;
            end
            GAP: begin
                if (gap_cnt_reg < GW'(GAP_BITS)) begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end else begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // Choose the next post-header bit. A 0 after "101" would complete
        // 1010, so a 1 is inserted instead; the same applies to the first
        // gap zero, hence the end-of-payload stuff.
        if (payload) begin
            if (bit_cnt_reg < BW'(WIDTH)) begin
                if (trk == T101 && !shreg_reg[WIDTH-1]) begin
                    state_next = STUFF;
                    out_next   = 1'b1;
                    stuff_next = 1'b1;
                end else begin
                    state_next   = DATA;
                    out_next     = shreg_reg[WIDTH-1];
                    shreg_next   = shreg_reg << 1;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end else if (trk == T101) begin
                state_next = STUFF;
                out_next   = 1'b1;
                stuff_next = 1'b1;
            end else begin
                state_next   = GAP;
                out_next     = 1'b0;
                gap_cnt_next = GW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            hdr_cnt_reg <= '0;
            out_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            stuff_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            hdr_cnt_reg <= hdr_cnt_next;
            out_reg     <= out_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            stuff_reg   <= stuff_next;
        end
    end

    assign bus.Out   = out_reg;
    assign bus.Busy  = busy_reg;
    assign bus.Done  = done_reg;
    assign bus.Stuff = stuff_reg;
    assign bus.cs    = state_reg;

endmodule

// File: doc/seq_1010_frame_tx.md
Name: seq_1010_frame_tx

Overview:
- Serial frame transmitter that is the sending end for the team's 1010 Mealy non-overlapping sequence detectors.
- Emits a 1010 sync header, then a WIDTH-bit payload MSB-first with bit-stuffing, then a zero gap.
- A downstream 1010 non-overlapping detector fires exactly once per frame, on the 4th header bit.
- Sits in the FSM test/demo datapath, driving a detector's serial input.

Parameters:
- WIDTH, 8: payload bits per frame (legal range 1..32).
- GAP_BITS, 2: trailing idle-zero bits per frame (minimum 2; lower values are illegal).

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous active-high reset
- Start  input  1  frame request; sampled only when Busy=0
- Data  input  WIDTH  payload; captured on the accepting edge
- Out  output  1  registered serial bit stream
- Busy  output  1  high from the edge after acceptance until the frame ends
- Done  output  1  one-cycle pulse in the first IDLE cycle after a frame
- Stuff  output  1  high while the current Out bit is a stuffed 1
- cs  output  3  current FSM state (debug)

Behaviour:
- Reset (async, Rst=1): state=IDLE, tracker=T0, Out=0, Busy=0, Done=0, Stuff=0, counters=0. Rst asserted mid-frame aborts the frame immediately; there is no Done pulse.
- Out, Busy, Done and Stuff are all registered. Each frame bit is valid on Out for exactly one clock.
- States: IDLE=0, HDR=1, DATA=2, STUFF=3, GAP=4. All other encodings go to IDLE.
- IDLE: Out=0. A rising edge with Start=1 (Busy=0):
  - latches Data into the shift register;
  - goes to HDR and drives Out=1, the first header bit.
  - Start while Busy=1 is ignored; there is no queuing.
- HDR: emits 1,0,1,0 over 4 cycles. The tracker is held at T0. After the 4th bit the FSM enters DATA.
- Tracker: a 2-bit suffix state over the post-header output bits.
  - States: T0=none, T1="1", T10="10", T101="101".
  - Next state: T0:1→T1,0→T0 | T1:1→T1,0→T10 | T10:1→T101,0→T0 | T101:1→T1,0→T0.
  - Updates on every DATA, STUFF and GAP bit.
- DATA: the next payload bit b = shreg MSB.
  - If tracker=T101 and b=0, go to STUFF instead and emit 1. Stuff=1 for that cycle; shreg is not shifted.
  - Otherwise emit b and shift left. The bit counter increments on payload bits only.
- STUFF: a single cycle, then return to DATA.
- End of payload (counter=WIDTH):
  - If tracker=T101, emit one end-stuff 1 (STUFF state, Stuff=1).
  - Then go to GAP.
- Guarantee: no 1010 ever appears in the post-header stream, including across the payload/gap boundary.
- GAP: emit GAP_BITS zeros. With GAP_BITS≥2 the tracker returns to T0, so a following header cannot misalign a detector.
- After the last gap bit: state=IDLE, Busy=0, Done=1 for one cycle. Start in that same cycle is accepted (back-to-back frames).
- Frame length = 4 + WIDTH + (number of stuffed bits) + GAP_BITS. The worst case is bounded by 4 + WIDTH + ceil(WIDTH/2) + 1 + GAP_BITS. Counters are sized for it.
- Busy is high for exactly the frame length in cycles.

Decomposition:
- Shared package seq_fsm_pkg:
  - frame-state localparams IDLE..GAP;
  - tracker encodings T0/T1/T10/T101;
  - HDR_PATTERN = 4'b1010;
  - MIN_GAP_BITS = 2.
- Sub-module seq_1010_tracker: tracker register plus next-state logic. Inputs are Clk, Rst, en, clr and bit; output is the 2-bit state. It is reusable by checker benches.

Test Plan:
- WIDTH=8, Data=8'hFF, one Start → Out = 1010 11111111 00. Busy high 14 cycles, Stuff never high, Done pulses once.
- Data=8'hA0 → Out = 1010 101[1]00000 00, where [1] is stuffed with Stuff=1. Busy 15 cycles.
- Data=8'hAA → Out = 1010 101[1]01[1]01[1]0 00. Three stuffs, Busy 17 cycles.
- Data=8'h05 → Out = 1010 00000101 [1] 00, with the end-stuff before the gap. Busy 15 cycles.
- Data=8'h5A, then Start re-asserted in the Done cycle, then Start pulsed mid-frame:
  - the second frame starts the next cycle, with no idle gap beyond GAP_BITS;
  - the mid-frame Start is ignored;
  - a 1010 non-overlapping detector on Out fires exactly once per frame, on the 4th header bit.
- Rst pulsed during DATA of Data=8'hC3 → Out=0, Busy=0, cs=0 without waiting for a clock edge, and no Done. A new Start then produces a clean full frame.
